// File: rtl/slcd_responder_if.sv
// slcd_responder_if: SPI pins plus buffer read port and status pulses of the serial LCD responder.
// Revision 1.0
`default_nettype none

interface slcd_responder_if #(
  parameter int AW = 5
);
  logic          ss;
  logic          sclk;
  logic          mosi;
  logic          miso;
  logic [7:0]    rxdata;
  logic          rxvalid;
  logic [AW-1:0] rdaddr;
  logic [7:0]    rddata;
  logic [AW-1:0] cursor;
  logic          clrdone;
  logic          rstdone;
  logic          seqerr;

  modport master (
    output ss, sclk, mosi, rdaddr,
    input  miso, rxdata, rxvalid, rddata, cursor, clrdone, rstdone, seqerr
  );

  modport slave (
    input  ss, sclk, mosi, rdaddr,
    output miso, rxdata, rxvalid, rddata, cursor, clrdone, rstdone, seqerr
  );
endinterface

`default_nettype wire

// File: rtl/slcd_responder.sv
// slcd_responder: SPI-slave serial LCD model with escape decoder and ROWS x COLS character buffer.
// Optional MISO echo of the previous byte with SLCD_RESPONDER_MISO_EN. Revision 1.0
`default_nettype none

module slcd_responder #(
  parameter int ROWS        = 2,
  parameter int COLS        = 16,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic     CLK,
  input  wire logic     RSTN,
  slcd_responder_if.slave bus
);
  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ESC,
    S_BRKT,
    S_PARAM,
    S_CLEAR
  } state_t;

  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   ss_s;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   sclk_rise;

  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    rx_byte;
  logic          rx_pulse;

  state_t        state;
  logic [AW-1:0] cursor;
  logic [AW-1:0] clr_addr;
  logic          silent;
  logic          clr_is_rst;
  logic [6:0]    p0;
  logic [6:0]    p1;
  logic          semi;
  logic          pend;
  logic [7:0]    pend_data;
  logic          clr_done;
  logic          rst_done;
  logic          seq_err;

  logic          have_byte;
  logic [7:0]    cur_byte;
  logic          is_print;
  logic          is_digit;
  logic [AW-1:0] cursor_next;
  logic [AW-1:0] goto_addr;
  logic          goto_ok;

  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_q;

  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev & ~ss_s;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      ss_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.ss};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_prev <= sclk_s;
    end
  end

  // SS high drops any partial byte; the byte lands one cycle after its 8th edge.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      rx_byte  <= 8'h00;
      rx_pulse <= 1'b0;
    end else begin
      rx_pulse <= 1'b0;
      if (ss_s) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        shreg   <= {shreg[6:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte  <= {shreg[6:0], mosi_s};
          rx_pulse <= 1'b1;
        end
      end
    end
  end

  function automatic logic [6:0] acc_digit(input logic [6:0] p, input logic [3:0] d);
    logic [10:0] t;
    t = 11'(p) * 11'd10 + 11'(d);
    return (t > 11'd99) ? 7'd99 : t[6:0];
  endfunction

  assign have_byte   = (state != S_CLEAR) && (pend || rx_pulse);
  assign cur_byte    = pend ? pend_data : rx_byte;
  assign is_print    = (cur_byte >= 8'h20) && (cur_byte <= 8'h7E);
  assign is_digit    = (cur_byte >= 8'h30) && (cur_byte <= 8'h39);
  assign cursor_next = (cursor == AW'(DEPTH - 1)) ? '0 : cursor + 1'b1;
  assign goto_ok     = (32'(p0) < ROWS) && (32'(p1) < COLS);
  assign goto_addr   = AW'(32'(p0) * COLS + 32'(p1));

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state      <= S_CLEAR;
      silent     <= 1'b1;
      clr_is_rst <= 1'b0;
      clr_addr   <= '0;
      cursor     <= '0;
      p0         <= 7'd0;
      p1         <= 7'd0;
      semi       <= 1'b0;
      pend       <= 1'b0;
      pend_data  <= 8'h00;
      clr_done   <= 1'b0;
      rst_done   <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      rst_done <= 1'b0;
      seq_err  <= 1'b0;

      if (state == S_CLEAR) begin
        if (rx_pulse) begin
          pend      <= 1'b1;
          pend_data <= rx_byte;
        end
      end else if (pend) begin
        if (rx_pulse) pend_data <= rx_byte;
        else          pend      <= 1'b0;
      end

      if (state == S_CLEAR) begin
        if (clr_addr == AW'(DEPTH - 1)) begin
          clr_addr <= '0;
          cursor   <= '0;
          state    <= S_IDLE;
          silent   <= 1'b0;
          if (!silent) begin
            clr_done <= ~clr_is_rst;
            rst_done <= clr_is_rst;
          end
        end else begin
          clr_addr <= clr_addr + 1'b1;
        end
      end else if (have_byte) begin
        if (state == S_IDLE) begin
          if (is_print)                cursor <= cursor_next;
          else if (cur_byte == 8'h1B)  state  <= S_ESC;
        end else if (state == S_ESC) begin
          if (cur_byte == 8'h5B) begin
            state <= S_BRKT;
            p0    <= 7'd0;
            p1    <= 7'd0;
            semi  <= 1'b0;
          end else begin
            seq_err <= 1'b1;
            state   <= S_IDLE;
          end
        end else begin
          if (is_digit) begin
            if (semi) p1 <= acc_digit(p1, cur_byte[3:0]);
            else      p0 <= acc_digit(p0, cur_byte[3:0]);
            state <= S_PARAM;
          end else if (cur_byte == 8'h3B) begin
            if (semi) begin
              seq_err <= 1'b1;
              state   <= S_IDLE;
            end else begin
              semi  <= 1'b1;
              state <= S_PARAM;
            end
          end else if (cur_byte == 8'h6A || cur_byte == 8'h2A) begin
            state      <= S_CLEAR;
            clr_addr   <= '0;
            silent     <= 1'b0;
            clr_is_rst <= (cur_byte == 8'h2A);
          end else if (cur_byte == 8'h48) begin
            if (goto_ok) cursor  <= goto_addr;
            else         seq_err <= 1'b1;
            state <= S_IDLE;
          end else begin
            seq_err <= 1'b1;
            state   <= S_IDLE;
          end
        end
      end
    end
  end

  always_comb begin
    we    = 1'b0;
    waddr = cursor;
    wdata = cur_byte;
    if (state == S_CLEAR) begin
      we    = 1'b1;
      waddr = clr_addr;
      wdata = 8'h20;
    end else if (state == S_IDLE && have_byte && is_print) begin
      we = 1'b1;
    end
  end

  // Read before write: a same-cycle write to the read address returns old data.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    rd_q <= mem[bus.rdaddr];
  end

`ifdef SLCD_RESPONDER_MISO_EN
  logic       ss_prev;
  logic [7:0] tx_sh;
  logic       miso_q;

  // Reload at SS fall and on the falling edge that follows each completed byte.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      ss_prev <= 1'b1;
      tx_sh   <= 8'h00;
      miso_q  <= 1'b0;
    end else begin
      ss_prev <= ss_s;
      if (ss_s) begin
        miso_q <= 1'b0;
      end else if (ss_prev || (sclk_prev && !sclk_s && bit_cnt == 3'd0)) begin
        miso_q <= rx_byte[7];
        tx_sh  <= {rx_byte[6:0], 1'b0};
      end else if (sclk_prev && !sclk_s) begin
        miso_q <= tx_sh[7];
        tx_sh  <= {tx_sh[6:0], 1'b0};
      end
    end
  end

  assign bus.miso = miso_q;
`else
  assign bus.miso = 1'b0;
`endif

  assign bus.rxdata  = rx_byte;
  assign bus.rxvalid = rx_pulse;
  assign bus.rddata  = rd_q;
  assign bus.cursor  = cursor;
  assign bus.clrdone = clr_done;
  assign bus.rstdone = rst_done;
  assign bus.seqerr  = seq_err;

endmodule

`default_nettype wire

// File: tb/tb_slcd_responder.sv
// tb_slcd_responder: scoreboard bench for slcd_responder (received bytes, buffer, cursor, pulses).
// Revision 1.0
`default_nettype none

module tb_slcd_responder;
  localparam int AW = 5;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  slcd_responder_if #(.AW(AW)) bus ();

  slcd_responder #(.ROWS(2), .COLS(16), .SYNC_STAGES(2)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int cyc = 0;
  int n_rx = 0, n_clr = 0, n_rst = 0, n_err = 0;
  int last_rx_cyc = 0, clr_cyc = -1, rst_cyc = -1;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (RSTN) begin
      if (bus.rxvalid) begin
        n_rx++;
        last_rx_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("rx_extra", 32'(bus.rxdata) | 32'h100, 32'h0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rx_byte", 32'(bus.rxdata), 32'(mon_exp));
        end
      end
      if (bus.clrdone) begin n_clr++; clr_cyc = cyc; end
      if (bus.rstdone) begin n_rst++; rst_cyc = cyc; end
      if (bus.seqerr)  n_err++;
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] cap);
    cap = 8'h00;
    for (int i = 0; i < n; i++) begin
      bus.mosi = b[7-i];
      #80;
      cap = {cap[6:0], bus.miso};
      bus.sclk = 1'b1;
      #80;
      bus.sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] cap);
    exp_q.push_back(b);
    spi_bits(b, 8, cap);
  endtask

  task automatic send(input string s, input bit esc);
    logic [7:0] cap;
    bus.ss = 1'b0;
    #80;
    if (esc) spi_byte(8'h1B, cap);
    for (int i = 0; i < s.len(); i++) spi_byte(s[i], cap);
    #80;
    bus.ss = 1'b1;
    #200;
  endtask

  task automatic rd(input int a, output logic [7:0] d);
    @(negedge CLK);
    bus.rdaddr = AW'(a);
    @(posedge CLK);
    #1 d = bus.rddata;
  endtask

  task automatic check_blank(input string tag);
    logic [7:0] d;
    for (int a = 0; a < 32; a++) begin
      rd(a, d);
      check(tag, 32'(d), 32'h20);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] cap;
    string hw;
    int base_rx, base_clr, base_rst, base_err;

    bus.ss = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0; bus.rdaddr = '0;
    RSTN = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RSTN = 1'b1;
    @(negedge CLK);
    check("rst_rxdata",  32'(bus.rxdata),  0);
    check("rst_rxvalid", 32'(bus.rxvalid), 0);
    check("rst_cursor",  32'(bus.cursor),  0);
    check("rst_pulses",  32'({bus.clrdone, bus.rstdone, bus.seqerr}), 0);
    check("rst_miso",    32'(bus.miso),    0);
    repeat (40) @(posedge CLK);
    check_blank("rst_blank");
    check("rst_no_done", 32'(n_clr + n_rst), 0);

    // Plain text in one window.
    hw = "hello world";
    base_rx = n_rx;
    send(hw, 1'b0);
    check("hw_rxcount", 32'(n_rx - base_rx), 11);
    for (int i = 0; i < 11; i++) begin
      rd(i, d);
      check("hw_cell", 32'(d), 32'(hw[i]));
    end
    check("hw_cursor", 32'(bus.cursor), 11);

    // Cursor positioning.
    send("[1;5H", 1'b1);
    check("goto_cursor", 32'(bus.cursor), 21);
    send("A", 1'b0);
    rd(21, d);
    check("goto_cell", 32'(d), 32'h41);
    check("goto_after", 32'(bus.cursor), 22);

    // Clear command.
    send("xy", 1'b0);
    base_clr = n_clr; base_rst = n_rst; clr_cyc = -1;
    send("[j", 1'b1);
    #600;
    check("clr_count", 32'(n_clr - base_clr), 1);
    check("clr_rstcnt", 32'(n_rst - base_rst), 0);
    check("clr_latency", 32'(clr_cyc - last_rx_cyc), 33);
    check("clr_cursor", 32'(bus.cursor), 0);
    check_blank("clr_blank");

    // Reset command.
    send("q", 1'b0);
    base_clr = n_clr; base_rst = n_rst; rst_cyc = -1;
    send("[*", 1'b1);
    #600;
    check("rstc_count", 32'(n_rst - base_rst), 1);
    check("rstc_clrcnt", 32'(n_clr - base_clr), 0);
    check("rstc_latency", 32'(rst_cyc - last_rx_cyc), 33);
    check("rstc_cursor", 32'(bus.cursor), 0);
    rd(0, d);
    check("rstc_cell0", 32'(d), 32'h20);

    // Sequence errors leave the cursor alone.
    send("[0;3H", 1'b1);
    check("err_setup", 32'(bus.cursor), 3);
    base_err = n_err;
    send("[3;0H", 1'b1);
    send("x", 1'b1);
    check("err_count", 32'(n_err - base_err), 2);
    check("err_cursor", 32'(bus.cursor), 3);
    send("[1;15H", 1'b1);
    check("goto_last", 32'(bus.cursor), 31);
    base_err = n_err;
    send("[1;16H", 1'b1);
    send("[123;4H", 1'b1);
    send("[1;2;", 1'b1);
    check("err_bounds", 32'(n_err - base_err), 3);
    check("err_bounds_cur", 32'(bus.cursor), 31);

    // Partial byte dropped on SS rise.
    send("[j", 1'b1);
    #600;
    base_rx = n_rx;
    bus.ss = 1'b0;
    #80;
    spi_bits(8'hFF, 4, cap);
    bus.ss = 1'b1;
    #400;
    check("partial_none", 32'(n_rx - base_rx), 0);
    send("A", 1'b0);
    check("partial_next", 32'(n_rx - base_rx), 1);
    rd(0, d);
    check("partial_cell", 32'(d), 32'h41);
    check("partial_cursor", 32'(bus.cursor), 1);

    // Wraparound after 32 characters.
    send("[j", 1'b1);
    #600;
    send("abcdefghijklmnopqrstuvwxyzABCDEF", 1'b0);
    check("wrap_cursor0", 32'(bus.cursor), 0);
    send("Z", 1'b0);
    rd(0, d);
    check("wrap_cell0", 32'(d), 32'h5A);
    rd(1, d);
    check("wrap_cell1", 32'(d), 32'h62);
    rd(31, d);
    check("wrap_cell31", 32'(d), 32'h46);
    check("wrap_cursor", 32'(bus.cursor), 1);

    // MISO echoes the previous byte only in the echo build.
    bus.ss = 1'b0;
    #80;
    spi_byte(8'h5A, cap);
    spi_byte(8'hC3, cap);
    #80;
    bus.ss = 1'b1;
    #200;
`ifdef SLCD_RESPONDER_MISO_EN
    check("miso_echo", 32'(cap), 32'h5A);
`else
    check("miso_zero", 32'(cap), 32'h00);
`endif

    check("rx_missing", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
